// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor speed meter and its telemetry slot.
package motor_pkg;

    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned PERIOD_W_DEF = 24;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic                 sat;
        logic                 ovr;
    } speed_sample_t;

    // All-ones value of a w-bit counter, i.e. its saturation ceiling.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/motor_sample_slot.sv
// One-entry valid/ready holding register. A load that finds the slot full and
// not being drained is dropped; the next sample that gets through carries ovr.
module motor_sample_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ovr_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              ovr_q,   ovr_d;
    logic              drop_q,  drop_d;
    logic              accept;
    logic              take;

    assign accept = valid_q && ready_i;
    assign take   = load_i && (!valid_q || accept);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        drop_d  = drop_q;
        if (take) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ovr_d   = drop_q;
            drop_d  = 1'b0;
        end else begin
            if (load_i) begin
                drop_d = 1'b1;
            end
            if (accept) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every flop samples the same pre-edge values.
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/motor_speed_meter.sv
// Turns the encoder edge strobe into per-window edge count, edge-to-edge
// period and signed position for the servo loop and register bridge.
module motor_speed_meter
    import motor_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned PERIOD_W    = PERIOD_W_DEF,
    parameter int unsigned POS_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                edge_pulse,
    input  logic                dir,
    input  logic                clear_pos,
    output logic [CNT_W-1:0]    speed_count,
    output logic                speed_sat,
    output logic                speed_ovr,
    output logic                speed_valid,
    input  logic                speed_ready,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled,
    output logic [POS_W-1:0]    position
);

    localparam int unsigned         GATE_W     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]   GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(sat_max(CNT_W));
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = PERIOD_W'(sat_max(PERIOD_W));

    state_e              state_q,   state_d;
    logic [GATE_W-1:0]   gate_q,    gate_d;
    logic [CNT_W-1:0]    win_q,     win_d;
    logic                wsat_q,    wsat_d;
    logic [PERIOD_W-1:0] per_q,     per_d;
    logic                armed_q,   armed_d;
    logic                stalled_q, stalled_d;
    logic [PERIOD_W-1:0] period_q,  period_d;
    logic                pvalid_q,  pvalid_d;
    logic [POS_W-1:0]    pos_q,     pos_d;

    logic                active;
    logic                close;
    logic                win_full;
    logic [CNT_W-1:0]    win_inc;
    logic                win_inc_sat;
    logic [CNT_W:0]      slot_data;

    assign state_d     = en ? RUN : IDLE;
    assign active      = (state_q == RUN) && en;
    assign close       = active && (gate_q == GATE_LAST);
    assign win_full    = (win_q == CNT_MAX);
    assign win_inc     = (edge_pulse && !win_full) ? win_q + 1'b1 : win_q;
    assign win_inc_sat = wsat_q || (edge_pulse && win_full);

    // Leaving RUN (or never entering it) zeroes the window and period tracking.
    always_comb begin
        gate_d    = '0;
        win_d     = '0;
        wsat_d    = 1'b0;
        per_d     = '0;
        armed_d   = 1'b0;
        stalled_d = 1'b0;
        period_d  = period_q;
        pvalid_d  = 1'b0;
        if (active) begin
            gate_d = close ? '0 : gate_q + 1'b1;
            if (!close) begin
                win_d  = win_inc;
                wsat_d = win_inc_sat;
            end
            if (edge_pulse) begin
                per_d   = PERIOD_W'(1);
                armed_d = 1'b1;
                if (armed_q && !stalled_q) begin
                    period_d = per_q;
                    pvalid_d = 1'b1;
                end
            end else begin
                per_d     = (per_q == PERIOD_MAX) ? per_q : per_q + 1'b1;
                armed_d   = armed_q;
                stalled_d = stalled_q || (per_q == PERIOD_MAX);
            end
        end
    end

    // Position tracks edges regardless of en; clear wins over a same-cycle edge.
    always_comb begin
        pos_d = pos_q;
        if (clear_pos) begin
            pos_d = '0;
        end else if (edge_pulse) begin
            pos_d = dir ? pos_q + 1'b1 : pos_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gate_q    <= '0;
            win_q     <= '0;
            wsat_q    <= 1'b0;
            per_q     <= '0;
            armed_q   <= 1'b0;
            stalled_q <= 1'b0;
            period_q  <= '0;
            pvalid_q  <= 1'b0;
            pos_q     <= '0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            win_q     <= win_d;
            wsat_q    <= wsat_d;
            per_q     <= per_d;
            armed_q   <= armed_d;
            stalled_q <= stalled_d;
            period_q  <= period_d;
            pvalid_q  <= pvalid_d;
            pos_q     <= pos_d;
        end
    end

    motor_sample_slot #(
        .DATA_W (CNT_W + 1)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (close),
        .data_i  ({win_inc, win_inc_sat}),
        .ready_i (speed_ready),
        .valid_o (speed_valid),
        .data_o  (slot_data),
        .ovr_o   (speed_ovr)
    );

    assign speed_count  = slot_data[CNT_W:1];
    assign speed_sat    = slot_data[0];
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign stalled      = stalled_q;
    assign position     = pos_q;

endmodule

// File: tb/tb_motor_speed_meter.sv
// Directed bench for motor_speed_meter with a speed-sample scoreboard and a
// period scoreboard, both fed as stimulus is driven.
module tb_motor_speed_meter;
    import motor_pkg::*;

    localparam int unsigned GATE = 20;
    localparam int unsigned CW   = 4;
    localparam int unsigned PW   = 6;
    localparam int unsigned PSW  = 32;
    localparam int          CMAX = (1 << CW) - 1;
    localparam int unsigned PAD  = 64 - $bits(speed_sample_t);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          edge_pulse = 1'b0;
    logic          dir = 1'b0;
    logic          clear_pos = 1'b0;
    logic          speed_ready = 1'b1;
    logic [CW-1:0] speed_count;
    logic          speed_sat;
    logic          speed_ovr;
    logic          speed_valid;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          stalled;
    logic [PSW-1:0] position;

    int n_cmp = 0;
    int n_bad = 0;

    speed_sample_t exp_q[$];
    int unsigned   per_exp_q[$];
    bit            chk_period = 1'b0;

    // Reference model of the window counter as seen from the bench.
    bit m_state = 1'b0;
    int m_gate = 0;
    int m_cnt = 0;
    bit m_sat = 1'b0;
    bit m_ovr_next = 1'b0;

    motor_speed_meter #(
        .GATE_CYCLES (GATE),
        .CNT_W       (CW),
        .PERIOD_W    (PW),
        .POS_W       (PSW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .edge_pulse   (edge_pulse),
        .dir          (dir),
        .clear_pos    (clear_pos),
        .speed_count  (speed_count),
        .speed_sat    (speed_sat),
        .speed_ovr    (speed_ovr),
        .speed_valid  (speed_valid),
        .speed_ready  (speed_ready),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .position     (position)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pos_val(input int v);
        logic [31:0] w;
        w = v;
        return {32'b0, w};
    endfunction

    function automatic logic [63:0] pack_sample(input speed_sample_t s);
        return {{PAD{1'b0}}, s};
    endfunction

    task automatic drive_cycle(input logic e, input logic d, input logic c);
        bit            active;
        int            nc;
        bit            ns;
        speed_sample_t s;
        edge_pulse = e;
        dir        = d;
        clear_pos  = c;
        active     = m_state && en;
        @(posedge clk);
        #1;
        if (active) begin
            nc = (e && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
            ns = m_sat || (e && m_cnt == CMAX);
            if (m_gate == GATE - 1) begin
                s.count = 16'(nc);
                s.sat   = ns;
                s.ovr   = m_ovr_next;
                exp_q.push_back(s);
                m_ovr_next = 1'b0;
                m_gate = 0;
                m_cnt  = 0;
                m_sat  = 1'b0;
            end else begin
                m_gate++;
                m_cnt = nc;
                m_sat = ns;
            end
        end else begin
            m_gate = 0;
            m_cnt  = 0;
            m_sat  = 1'b0;
        end
        m_state = en;
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b0;
        edge_pulse = 1'b0;
        clear_pos  = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        m_state    = 1'b0;
        m_gate     = 0;
        m_cnt      = 0;
        m_sat      = 1'b0;
        m_ovr_next = 1'b0;
        exp_q.delete();
        per_exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_speed_valid"},  64'(speed_valid),  64'd0);
        check({tag, "_speed_count"},  64'(speed_count),  64'd0);
        check({tag, "_speed_sat"},    64'(speed_sat),    64'd0);
        check({tag, "_speed_ovr"},    64'(speed_ovr),    64'd0);
        check({tag, "_period"},       64'(period),       64'd0);
        check({tag, "_period_valid"}, 64'(period_valid), 64'd0);
        check({tag, "_stalled"},      64'(stalled),      64'd0);
        check({tag, "_position"},     64'(position),     64'd0);
    endtask

    // Output monitor: pops scoreboards on handshakes and checks held samples.
    always @(negedge clk) begin
        speed_sample_t obs;
        if (rst && speed_valid) begin
            obs.count = 16'(speed_count);
            obs.sat   = speed_sat;
            obs.ovr   = speed_ovr;
            check("speed_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check(speed_ready ? "speed_sample" : "speed_hold", pack_sample(obs), pack_sample(exp_q[0]));
                if (speed_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
        if (rst && chk_period && period_valid) begin
            check("period_pending", 64'(per_exp_q.size() != 0), 64'd1);
            if (per_exp_q.size() != 0) begin
                check("period", 64'(period), 64'(per_exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        do_reset(3);
        check_all_zero("reset");
        rst         = 1'b1;
        speed_ready = 1'b1;

        // Test 1: five edges per window, consumer always ready
        en = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b0);
        repeat (3) begin
            for (int g = 0; g < GATE; g++) drive_cycle(g % 4 == 0, 1'b1, 1'b0);
        end

        // Test 2: saturating window followed by an empty window
        for (int g = 0; g < GATE; g++) drive_cycle(1'b1, 1'b1, 1'b0);
        for (int g = 0; g < GATE; g++) drive_cycle(1'b0, 1'b1, 1'b0);

        // Test 3: consumer stalls across three windows
        for (int w = 0; w < 5; w++) begin
            for (int g = 0; g < GATE; g++) begin
                if (w == 0 && g == 2) speed_ready = 1'b0;
                if (w == 3 && g == 2) speed_ready = 1'b1;
                drive_cycle(g < w + 3, 1'b1, 1'b0);
            end
            if (w == 2) begin
                void'(exp_q.pop_back());
                void'(exp_q.pop_back());
                m_ovr_next = 1'b1;
            end
        end

        // Test 4: period, stall and recovery after re-entering RUN
        en = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        en = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b0);
        chk_period = 1'b1;
        repeat (10) drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        repeat (49) drive_cycle(1'b0, 1'b1, 1'b0);
        per_exp_q.push_back(50);
        drive_cycle(1'b1, 1'b1, 1'b0);
        check("stalled_after_edge", 64'(stalled), 64'd0);
        repeat (70) drive_cycle(1'b0, 1'b1, 1'b0);
        check("stalled_set", 64'(stalled), 64'd1);
        drive_cycle(1'b1, 1'b1, 1'b0);
        check("stalled_cleared", 64'(stalled), 64'd0);
        repeat (29) drive_cycle(1'b0, 1'b1, 1'b0);
        per_exp_q.push_back(30);
        drive_cycle(1'b1, 1'b1, 1'b0);
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b0);
        check("period_hold", 64'(period), 64'd30);
        check("period_drained", 64'(per_exp_q.size()), 64'd0);
        chk_period = 1'b0;

        // Test 5: position, including updates while idle
        en = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b1);
        check("pos_clear", 64'(position), pos_val(0));
        repeat (7) drive_cycle(1'b1, 1'b1, 1'b0);
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
        check("pos_plus4", 64'(position), pos_val(4));
        drive_cycle(1'b1, 1'b1, 1'b1);
        check("pos_clear_edge", 64'(position), pos_val(0));
        repeat (5) drive_cycle(1'b1, 1'b0, 1'b0);
        check("pos_minus5", 64'(position), pos_val(-5));

        // Test 6: reset mid-window with a pending sample
        en = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b0);
        speed_ready = 1'b0;
        for (int g = 0; g < GATE; g++) drive_cycle(g < 17, 1'b1, 1'b0);
        repeat (5) drive_cycle(1'b0, 1'b1, 1'b0);
        check("pre_reset_valid", 64'(speed_valid), 64'd1);
        check("pre_reset_pos", 64'(position), pos_val(12));
        do_reset(1);
        check_all_zero("midreset");
        rst         = 1'b1;
        speed_ready = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b0);
        for (int g = 0; g < GATE; g++) drive_cycle(g == 0 || g == GATE - 1, 1'b1, 1'b0);
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b0);
        check("speed_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/motor_speed_meter.md
Name: motor_speed_meter

Overview:
Downstream consumer of the single-cycle encoder edge strobe produced by the motor edge-detect stage. It turns that strobe into three measurements for the servo control loop and the STM32 register bridge:
- edge count per fixed gate window (speed), delivered through a valid/ready handshake;
- edge-to-edge period in clock cycles;
- signed accumulated position.

Parameters:
GATE_CYCLES, 100000, gate window length in clk cycles (>=2)
CNT_W, 16, width of per-window edge count
PERIOD_W, 24, width of edge-to-edge period counter
POS_W, 32, width of signed position accumulator

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
en  input  1  measurement enable
edge_pulse  input  1  one-cycle strobe per encoder edge, from edge-detect stage
dir  input  1  1 = forward (+1 per edge), 0 = reverse (-1 per edge)
clear_pos  input  1  synchronous position clear
speed_count  output  CNT_W  edges counted in last completed window
speed_sat  output  1  count saturated in that window
speed_ovr  output  1  at least one window dropped before this sample
speed_valid  output  1  sample available
speed_ready  input  1  consumer accepts sample
period  output  PERIOD_W  cycles between last two edges
period_valid  output  1  one-cycle strobe, period updated
stalled  output  1  no edge for 2^PERIOD_W-1 cycles
position  output  POS_W  signed position, two's complement

Behaviour:
- Reset (rst==0): all outputs 0; state IDLE; gate counter, window count, period counter, armed flag and drop flag cleared. Takes effect in the same cycle it is sampled, including mid-window.
- States:
  - IDLE: counters held at 0.
  - RUN: entered the cycle after en==1 is sampled.
  - RUN→IDLE on en==0: partial window discarded, armed cleared, stalled cleared. A pending speed sample stays valid until accepted.
- Gate counter in RUN counts 0..GATE_CYCLES-1 and wraps. The window closes on the cycle the counter equals GATE_CYCLES-1.
- Window count: +1 per edge_pulse in RUN, saturating at 2^CNT_W-1 with a sticky sat bit per window. An edge on the closing cycle belongs to the closing window. The next window starts at 0, or at 1 if edge_pulse is also present on the first cycle.
- Output slot (one entry):
  - On window close, the slot loads next cycle if it is empty or being accepted that cycle (speed_valid && speed_ready).
  - Load sets speed_count, speed_sat, speed_ovr=drop flag, speed_valid=1, and clears the drop flag.
  - If the slot is full and not accepted: sample dropped, drop flag set.
  - speed_valid and data hold stable while !speed_ready. The slot clears on handshake when no load occurs.
  - Latency from window close to speed_valid: 1 cycle.
- Period:
  - Period counter increments every RUN cycle and resets to 1 on edge_pulse.
  - On edge_pulse with armed==1 and stalled==0: period = counter value before reset (edges at cycles t and t+N give N), and period_valid pulses on the next cycle.
  - The first edge after reset or RUN entry only arms; no period_valid.
  - When the counter reaches 2^PERIOD_W-1: stalled=1 and the counter holds.
  - The next edge clears stalled and re-arms; no period_valid for that edge.
- Position:
  - Updates in any state, including IDLE, on edge_pulse: +1 if dir, else -1. Wraps modulo 2^POS_W.
  - clear_pos has priority: a simultaneous edge is discarded and position becomes 0.
  - Latency 1 cycle.

Decomposition:
- Package motor_pkg:
  - state enum {IDLE, RUN};
  - localparam helpers for the saturation maxima (CNT_MAX, PERIOD_MAX);
  - typedef struct for the speed sample {count, sat, ovr}.
- Sub-module motor_sample_slot: the one-entry valid/ready holding register with drop flag, reusable for other telemetry.

Test Plan:
Parameters used below: GATE_CYCLES=20, CNT_W=4, PERIOD_W=6.
1. en=1, edge every 4 cycles (5 per window), speed_ready=1 -> speed_valid pulses once per window with speed_count=5, sat=0, ovr=0.
2. en=1, edge every cycle for 20 cycles -> speed_count=15, speed_sat=1; following idle window gives count=0, sat=0.
3. speed_ready=0 for 3 windows, then 1 -> first sample held stable throughout; two windows dropped; next loaded sample has speed_ovr=1; the one after has speed_ovr=0.
4. Edges at cycles 10, 60 -> no period_valid after edge 1; period=50, period_valid high 1 cycle after edge 2. No edges for 63+ cycles -> stalled=1. Next edge -> stalled=0, no period_valid. Edge 30 cycles later -> period=30.
5. 7 forward edges, 3 reverse edges -> position=4. clear_pos coincident with an edge -> position=0. 5 reverse edges -> position=-5.
6. Assert rst=0 mid-window with speed_valid=1 and position=12 -> next cycle all outputs 0, state IDLE. en held at 1 -> first window after release is a full 20 cycles.
